// File: rtl/uart_rx_frame_receiver_if.sv
// Serial line plus received-pack outputs of the UART receive core.
// slave = receiver side, master = line driver / pack consumer.
interface uart_rx_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 IN_RX_SERIAL;
    logic [DATA_BITS-1:0] OUT_RX_DATA;
    logic                 OUT_RX_DATA_READY;
    logic                 OUT_RX_PARITY_ERROR;
    logic                 OUT_RX_FRAME_ERROR;
    logic                 OUT_RX_ERROR;
    logic                 OUT_RX_ACTIVE;

    modport slave (
        input  IN_RX_SERIAL,
        output OUT_RX_DATA, OUT_RX_DATA_READY, OUT_RX_PARITY_ERROR,
               OUT_RX_FRAME_ERROR, OUT_RX_ERROR, OUT_RX_ACTIVE
    );

    modport master (
        output IN_RX_SERIAL,
        input  OUT_RX_DATA, OUT_RX_DATA_READY, OUT_RX_PARITY_ERROR,
               OUT_RX_FRAME_ERROR, OUT_RX_ERROR, OUT_RX_ACTIVE
    );
endinterface

// File: rtl/uart_rx_frame_receiver.sv
// UART receive core: start, LSB-first data, optional parity, N stop bits,
// mid-bit sampling, one-cycle ready strobe with per-frame error flags.
module uart_rx_frame_receiver #(
    parameter int UART_BAUD_RATE           = 9600,
    parameter int CLOCK_FREQUENCY          = 50000000,
    parameter int PARITY                   = 1,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int NUMBER_STOP_BITS         = 2
) (
    input  logic                     IN_CLOCK,
    input  logic                     IN_RESET_N,
    uart_rx_frame_receiver_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam int DW           = NUM_OF_DATA_BITS_IN_PACK;
    localparam int IW           = $clog2(DW);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);
    localparam logic          STOP_LAST = (NUMBER_STOP_BITS == 2);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_rx_meta, r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_bit_idx;
    logic            r_stop_idx;
    logic [DW-1:0]   r_shift;
    logic            r_pe_latch, r_fe_latch;
    logic [DW-1:0]   r_data;
    logic            r_ready, r_perr, r_ferr, r_err, r_active;

    // Synchroniser presets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.IN_RX_SERIAL;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_pe_latch <= 1'b0;
            r_fe_latch <= 1'b0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_err      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state  <= S_START;
                        r_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_pe_latch <= 1'b0;
                        r_fe_latch <= 1'b0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (r_rx_s) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == IDX_LAST) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt      <= '0;
                        r_pe_latch <= ((^r_shift) ^ r_rx_s) != ODD;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (!r_rx_s) r_fe_latch <= 1'b1;
                        if (r_stop_idx == STOP_LAST) r_state <= S_DONE;
                        else                         r_stop_idx <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_cnt    <= '0;
                    r_data   <= r_shift;
                    r_perr   <= r_pe_latch;
                    r_ferr   <= r_fe_latch;
                    r_err    <= r_pe_latch | r_fe_latch;
                    r_ready  <= 1'b1;
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.OUT_RX_DATA         = r_data;
    assign bus.OUT_RX_DATA_READY   = r_ready;
    assign bus.OUT_RX_PARITY_ERROR = r_perr;
    assign bus.OUT_RX_FRAME_ERROR  = r_ferr;
    assign bus.OUT_RX_ERROR        = r_err;
    assign bus.OUT_RX_ACTIVE       = r_active;
endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Directed bench: frames are pushed into an expectation queue as they are sent;
// one negedge process checks every strobe and the held outputs between strobes.
module tb_uart_rx_frame_receiver;
    localparam int CPB = 16;
    localparam int LAT = 2 + CPB/2 + CPB*(8 + 1 + 2) + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;
    exp_t q[$];

    logic [7:0] h_d;
    logic       h_pe, h_fe;

    uart_rx_frame_receiver_if #(.DATA_BITS(8)) bus ();

    uart_rx_frame_receiver #(
        .UART_BAUD_RATE(100), .CLOCK_FREQUENCY(1600), .PARITY(1),
        .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(2)
    ) dut (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: outputs hold the last delivered frame; a strobe must match the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_data",   {24'd0, bus.OUT_RX_DATA}, 32'd0);
            chk("rst_ready",  {31'd0, bus.OUT_RX_DATA_READY}, 32'd0);
            chk("rst_perr",   {31'd0, bus.OUT_RX_PARITY_ERROR}, 32'd0);
            chk("rst_ferr",   {31'd0, bus.OUT_RX_FRAME_ERROR}, 32'd0);
            chk("rst_err",    {31'd0, bus.OUT_RX_ERROR}, 32'd0);
            chk("rst_active", {31'd0, bus.OUT_RX_ACTIVE}, 32'd0);
            h_d = 8'h00; h_pe = 1'b0; h_fe = 1'b0;
        end else if (bus.OUT_RX_DATA_READY === 1'b1) begin
            strobes++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: got strobe with data %0h expected none", bus.OUT_RX_DATA);
            end else begin
                exp_t e;
                int lat;
                e = q.pop_front();
                lat = cyc - e.t0;
                chk("strobe_data", {24'd0, bus.OUT_RX_DATA}, {24'd0, e.d});
                chk("strobe_perr", {31'd0, bus.OUT_RX_PARITY_ERROR}, {31'd0, e.pe});
                chk("strobe_ferr", {31'd0, bus.OUT_RX_FRAME_ERROR}, {31'd0, e.fe});
                chk("strobe_err",  {31'd0, bus.OUT_RX_ERROR}, {31'd0, e.pe | e.fe});
                checks++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    errors++;
                    $display("FAIL latency: got %0d expected %0d+/-1", lat, LAT);
                end
                h_d = e.d; h_pe = e.pe; h_fe = e.fe;
            end
        end else begin
            chk("hold_data", {24'd0, bus.OUT_RX_DATA}, {24'd0, h_d});
            chk("hold_perr", {31'd0, bus.OUT_RX_PARITY_ERROR}, {31'd0, h_pe});
            chk("hold_ferr", {31'd0, bus.OUT_RX_FRAME_ERROR}, {31'd0, h_fe});
            chk("hold_err",  {31'd0, bus.OUT_RX_ERROR}, {31'd0, h_pe | h_fe});
        end
    end

    task automatic drive_bit(input logic b);
        bus.IN_RX_SERIAL = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.IN_RX_SERIAL = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        exp_t e;
        e.d  = d;
        e.pe = ((^d) ^ pbit) != 1'b0;
        e.fe = !s1 || !s2;
        e.t0 = cyc;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(s1);
        drive_bit(s2);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: got %0d frames pending expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic saw;
        logic [7:0] v55;
        bus.IN_RX_SERIAL = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_data", {24'd0, bus.OUT_RX_DATA}, 32'd0);
        chk("reset_active", {31'd0, bus.OUT_RX_ACTIVE}, 32'd0);
        idle(10);

        // 1: clean frame
        s0 = strobes;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        drain("t1_drain");
        chk("t1_strobes", strobes - s0, 32'd1);
        chk("t1_data", {24'd0, bus.OUT_RX_DATA}, 32'hA5);
        chk("t1_err", {31'd0, bus.OUT_RX_ERROR}, 32'd0);
        chk("t1_active", {31'd0, bus.OUT_RX_ACTIVE}, 32'd0);
        idle(10);

        // 2: parity error
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        drain("t2_drain");
        chk("t2_data", {24'd0, bus.OUT_RX_DATA}, 32'h3C);
        chk("t2_perr", {31'd0, bus.OUT_RX_PARITY_ERROR}, 32'd1);
        chk("t2_err", {31'd0, bus.OUT_RX_ERROR}, 32'd1);
        chk("t2_ferr", {31'd0, bus.OUT_RX_FRAME_ERROR}, 32'd0);
        idle(10);

        // 3: framing error on second stop bit, then a clean frame clears flags
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        drain("t3a_drain");
        chk("t3_data", {24'd0, bus.OUT_RX_DATA}, 32'h81);
        chk("t3_ferr", {31'd0, bus.OUT_RX_FRAME_ERROR}, 32'd1);
        idle(10);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        drain("t3b_drain");
        chk("t3_clear_ferr", {31'd0, bus.OUT_RX_FRAME_ERROR}, 32'd0);
        chk("t3_clear_perr", {31'd0, bus.OUT_RX_PARITY_ERROR}, 32'd0);
        idle(10);

        // 4: short low glitch, no frame
        s0 = strobes;
        saw = 1'b0;
        bus.IN_RX_SERIAL = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw |= bus.OUT_RX_ACTIVE;
        end
        bus.IN_RX_SERIAL = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            saw |= bus.OUT_RX_ACTIVE;
        end
        chk("t4_active_seen", {31'd0, saw}, 32'd1);
        chk("t4_active_low", {31'd0, bus.OUT_RX_ACTIVE}, 32'd0);
        chk("t4_strobes", strobes - s0, 32'd0);
        chk("t4_data", {24'd0, bus.OUT_RX_DATA}, 32'h01);

        // 5: back to back frames
        s0 = strobes;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        drain("t5_drain");
        chk("t5_strobes", strobes - s0, 32'd2);
        chk("t5_data", {24'd0, bus.OUT_RX_DATA}, 32'hFF);
        idle(10);

        // 6: reset during bit 4 of 0x55, then clean 0x66
        s0 = strobes;
        v55 = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v55[i]);
        bus.IN_RX_SERIAL = v55[4];
        repeat (CPB/2) @(posedge clk);
        #1;
        chk("t6_active_mid", {31'd0, bus.OUT_RX_ACTIVE}, 32'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.IN_RX_SERIAL = 1'b1;
        rst_n = 1'b1;
        idle(CPB * 8);
        chk("t6_no_strobe", strobes - s0, 32'd0);
        chk("t6_data_cleared", {24'd0, bus.OUT_RX_DATA}, 32'd0);
        send_frame(8'h66, 1'b0, 1'b1, 1'b1);
        drain("t6_drain");
        chk("t6_data", {24'd0, bus.OUT_RX_DATA}, 32'h66);
        chk("t6_err", {31'd0, bus.OUT_RX_ERROR}, 32'd0);
        chk("t6_strobes", strobes - s0, 32'd1);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
